onehot_serial_encoder: RTL
==========================

// Module: onehot_serial_encoder
// PURPOSE
//  Parametrised, sequential successor of the 8-to-3 encoder. Accepts an N-bit request
//  vector that may have any number of bits set. Emits the index of every set bit, one per
//  beat, in priority order, over valid/ready handshakes. Index convention: bit N-1 -> 0,
//  bit 0 -> N-1 (MSB first).
//  Sits between request-collecting logic and any single-index consumer (mux select, decoder).
// PARAMETERS
//  N  8                      input vector width; legal range N >= 2
//  W  (N>1)?$clog2(N):1      index width; derived, do not override
// PORTS
//  clk        in   1    rising-edge clock
//  rst        in   1    synchronous reset, active-high
//  in         in   N    request vector
//  in_valid   in   1    request vector valid
//  in_ready   out  1    block can capture a vector this cycle
//  out        out  W    encoded index of current beat
//  out_valid  out  1    out/out_last valid
//  out_ready  in   1    consumer accepts current beat
//  out_last   out  1    current beat is the last index of the captured vector
//  busy       out  1    state == EMIT
// BEHAVIOUR
//  - Reset (rst=1 at posedge): state=IDLE, pending=0, out_valid=0, out=0, out_last=0, busy=0.
//  - Reset mid-EMIT drops all remaining indices; no beat is emitted the cycle after reset.
//  - States:
//    * IDLE: out_valid=0, out=0, out_last=0.
//    * EMIT: out_valid=1.
//  - in_ready = (state==IDLE) | (out_valid & out_last & out_ready).
//  - Capture happens on in_valid & in_ready: pending <= in.
//    * in != 0: next state is EMIT.
//    * in == 0: vector is discarded silently; state stays/returns IDLE, no beat emitted.
//  - EMIT combinational outputs, all derived from the pending register only:
//    * out = N-1-k, where k = highest set bit of pending.
//    * out_last = (pending has exactly one bit set).
//  - Beat handshake, on out_valid & out_ready:
//    * Clear bit k of pending.
//    * If out_last and no capture this cycle: go to IDLE.
//    * If out_last and a capture happens in the same cycle: load the new vector
//      (back-to-back, no bubble).
//  - Backpressure: with out_ready=0, out, out_last and pending hold stable; out_valid stays 1.
//  - Latency: capture at posedge t -> first out_valid at cycle t+1.
//  - Throughput: one index per cycle while out_ready=1.
//  - in is sampled only at capture. Changes to in during EMIT are ignored.
//  - in_valid while in_ready=0: no capture. The source must hold in and in_valid.
// CONFIGURATION
//  ONEHOT_ENC_COUNT_EN defined:
//   - Adds port cnt (out, W+1 bits) = popcount of the last captured vector.
//   - cnt is registered at capture and holds until the next capture.
//   - A zero vector captures cnt=0. Reset value is 0.
//  ONEHOT_ENC_COUNT_EN undefined: port cnt and its logic are absent; all else identical.
// TESTING (N=8, out_ready=1 unless stated)
//  1. in=8'b1000_0000 pulse -> next cycle one beat: out=0, out_last=1; then IDLE, in_ready=1.
//  2. in=8'b0000_0001 -> one beat: out=7, out_last=1.
//  3. in=8'b1010_0001 -> beats out=0,2,7 on consecutive cycles; out_last only on 7;
//     cnt=3 when COUNT_EN.
//  4. Case 3 with out_ready=0 for 3 cycles at the first beat -> out=0 held stable,
//     out_valid=1 for 3 cycles; then 0,2,7 follow.
//  5. in=8'h00 with in_valid -> in_ready stays 1, out_valid never asserts, cnt=0.
//  6. During case 3, assert rst after beat out=0 -> next cycle out_valid=0, in_ready=1;
//     then in=8'b0100_0000 -> one beat out=1.
//  7. Drive in=8'b0000_0110 on the last beat of case 3 -> accepted same cycle; beats 5,6
//     follow with no idle cycle.

Source files
------------

// File: rtl/onehot_serial_encoder.sv
// Serialises every set bit of a request vector into one index per valid/ready beat, MSB first.
// Optional popcount output cnt is enabled by defining ONEHOT_ENC_COUNT_EN.
module onehot_serial_encoder #(
    parameter int N = 8,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] in,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    output logic         busy
`ifdef ONEHOT_ENC_COUNT_EN
    ,
    output logic [W:0]   cnt
`endif
);

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    localparam logic [W-1:0] LAST_IDX = W'(N - 1);

    state_t       r_state;
    state_t       w_stateNext;
    logic [N-1:0] r_pending;
    logic [N-1:0] w_pendingNext;
    logic [W-1:0] w_topIdx;
    logic [N-1:0] w_topMask;
    logic         w_single;
    logic         w_capture;
    logic         w_beat;

    // Highest set bit of pending wins, since it maps to the smallest index.
    always_comb begin
        w_topIdx = '0;
        for (int i = 0; i < N; i++) begin
            if (r_pending[i]) begin
                w_topIdx = W'(i);
            end
        end
    end

    assign w_topMask = {{(N-1){1'b0}}, 1'b1} << w_topIdx;
    assign w_single  = (r_pending & (r_pending - {{(N-1){1'b0}}, 1'b1})) == '0;

    assign busy      = (r_state == EMIT);
    assign out_valid = (r_state == EMIT);
    assign out       = (r_state == EMIT) ? (LAST_IDX - w_topIdx) : '0;
    assign out_last  = (r_state == EMIT) & w_single;
    assign in_ready  = (r_state == IDLE) | (out_valid & out_last & out_ready);
    assign w_capture = in_valid & in_ready;
    assign w_beat    = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_pending <= '0;
        end else begin
            r_state   <= w_stateNext;
            r_pending <= w_pendingNext;
        end
    end

    // A capture can only coincide with the final beat, so it simply overrides the bit clear.
    always_comb begin
        w_stateNext   = r_state;
        w_pendingNext = r_pending;
        if (w_capture) begin
            w_pendingNext = in;
            w_stateNext   = (in != '0) ? EMIT : IDLE;
        end else if (w_beat) begin
            w_pendingNext = r_pending & ~w_topMask;
            if (out_last) begin
                w_stateNext = IDLE;
            end
        end
    end

`ifdef ONEHOT_ENC_COUNT_EN
    logic [W:0] r_cnt;
    logic [W:0] w_popCount;

    always_comb begin
        w_popCount = '0;
        for (int i = 0; i < N; i++) begin
            w_popCount = w_popCount + {{W{1'b0}}, in[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_capture) begin
            r_cnt <= w_popCount;
        end
    end

    assign cnt = r_cnt;
`endif

endmodule
